// File: rtl/regfile_wb_buffer_pkg.sv
// Widths shared by the regfile and the writeback buffer that feeds it.
package regfile_wb_buffer_pkg;

    localparam int RF_DATA_WIDTH    = 16;
    localparam int RF_REGADDR_WIDTH = 3;
    localparam int RF_NUM_REGS      = 1 << RF_REGADDR_WIDTH;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search of one lookup address over the queued writebacks.
module wb_fwd_match #(
    parameter int DEPTH         = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int REGADDR_WIDTH = 3,
    parameter int PTR_W         = $clog2(DEPTH)
) (
    input  logic [REGADDR_WIDTH-1:0]             i_addr,
    input  logic [PTR_W-1:0]                     i_head,
    input  logic [DEPTH-1:0]                     i_vld,
    input  logic [DEPTH-1:0][REGADDR_WIDTH-1:0]  i_reg,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0]     i_data,
    output logic                                 o_hit,
    output logic [DATA_WIDTH-1:0]                o_data
);

    logic [PTR_W-1:0] w_idx;

    // Walk oldest to youngest starting at head; valid entries are contiguous
    // from head, so the last match seen is the youngest one.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + PTR_W'(k);
            if (i_vld[w_idx] && (i_reg[w_idx] == i_addr)) begin
                o_hit  = 1'b1;
                o_data = i_data[w_idx];
            end
        end
    end

endmodule

// File: rtl/regfile_wb_buffer.sv
// In-order writeback FIFO in front of the regfile write port, with
// forwarding of queued-but-not-yet-written values to two read ports.
module regfile_wb_buffer
    import regfile_wb_buffer_pkg::*;
#(
    parameter int DATA_WIDTH    = RF_DATA_WIDTH,
    parameter int REGADDR_WIDTH = RF_REGADDR_WIDTH,
    parameter int DEPTH         = 4,
    localparam int PTR_W        = $clog2(DEPTH),
    localparam int CNT_W        = PTR_W + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [REGADDR_WIDTH-1:0] in_reg,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     wb_stall,
    output logic                     reg_write,
    output logic [REGADDR_WIDTH-1:0] write_reg,
    output logic [DATA_WIDTH-1:0]    write_data,
    input  logic [REGADDR_WIDTH-1:0] fwd_reg1,
    input  logic [REGADDR_WIDTH-1:0] fwd_reg2,
    output logic                     fwd_hit1,
    output logic [DATA_WIDTH-1:0]    fwd_data1,
    output logic                     fwd_hit2,
    output logic [DATA_WIDTH-1:0]    fwd_data2,
    output logic [CNT_W-1:0]         count,
    output logic                     empty
);

    logic [DEPTH-1:0][REGADDR_WIDTH-1:0] r_reg;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]    r_data;
    logic [DEPTH-1:0]                    r_vld;
    logic [PTR_W-1:0]                    r_head;
    logic [PTR_W-1:0]                    r_tail;
    logic [CNT_W-1:0]                    r_count;

    logic w_push;
    logic w_pop;

    // Ready depends only on registered occupancy: a pop in the same cycle
    // does not open a slot for a push-through.
    assign in_ready = (r_count != CNT_W'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;

    // Reset suppresses the write strobe so a reset edge never lets a queued
    // entry slip into the regfile while the queue is being discarded.
    assign reg_write  = !empty && !wb_stall && !reset;
    assign write_reg  = empty ? '0 : r_reg[r_head];
    assign write_data = empty ? '0 : r_data[r_head];

    assign w_push = in_valid && in_ready;
    assign w_pop  = reg_write;

    // FIFO pointers, occupancy and entry valid bits; payload written on push.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            if (w_push) begin
                r_reg[r_tail]  <= in_reg;
                r_data[r_tail] <= in_data;
                r_vld[r_tail]  <= 1'b1;
                r_tail         <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The head entry being popped still forwards: the regfile only takes it
    // at the edge. An incoming push is not visible until it is stored.
    wb_fwd_match #(
        .DEPTH         (DEPTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .REGADDR_WIDTH (REGADDR_WIDTH),
        .PTR_W         (PTR_W)
    ) u_fwd1 (
        .i_addr (fwd_reg1),
        .i_head (r_head),
        .i_vld  (r_vld),
        .i_reg  (r_reg),
        .i_data (r_data),
        .o_hit  (fwd_hit1),
        .o_data (fwd_data1)
    );

    wb_fwd_match #(
        .DEPTH         (DEPTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .REGADDR_WIDTH (REGADDR_WIDTH),
        .PTR_W         (PTR_W)
    ) u_fwd2 (
        .i_addr (fwd_reg2),
        .i_head (r_head),
        .i_vld  (r_vld),
        .i_reg  (r_reg),
        .i_data (r_data),
        .o_hit  (fwd_hit2),
        .o_data (fwd_data2)
    );

endmodule
